// File: rtl/xdma_finish_tx.sv
// Finish-write transmitter: queues {addr, dma_id} finish requests and issues
// each one as a single-beat write, waiting for its response before the next.
module xdma_finish_tx #(
  parameter int AddrWidth = 48,
  parameter int DataWidth = 512,
  parameter int IdWidth   = 8,
  parameter int FifoDepth = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 finish_valid_i,
  output logic                 finish_ready_o,
  input  logic [AddrWidth-1:0] finish_addr_i,
  input  logic [IdWidth-1:0]   finish_dma_id_i,
  output logic                 aw_valid_o,
  input  logic                 aw_ready_i,
  output logic [AddrWidth-1:0] aw_addr_o,
  output logic                 w_valid_o,
  input  logic                 w_ready_i,
  output logic [DataWidth-1:0] w_data_o,
  output logic                 w_last_o,
  input  logic                 b_valid_i,
  output logic                 b_ready_o,
  input  logic [1:0]           b_resp_i,
  output logic                 busy_o,
  output logic                 error_o,
  output logic [31:0]          sent_cnt_o
);

  localparam int PtrW = $clog2(FifoDepth);
  localparam logic [PtrW:0] Full = (PtrW+1)'(FifoDepth);

  typedef enum logic [1:0] {
    Idle     = 2'd0,
    Issue    = 2'd1,
    WaitResp = 2'd2
  } state_t;

  logic [AddrWidth-1:0] addr_mem [FifoDepth];
  logic [IdWidth-1:0]   id_mem   [FifoDepth];
  logic [PtrW-1:0]      wr_ptr;
  logic [PtrW-1:0]      rd_ptr;
  logic [PtrW:0]        count;
  state_t               state;
  logic                 aw_done;
  logic                 w_done;

  logic push;
  logic pop;
  logic aw_fire;
  logic w_fire;

  assign finish_ready_o = (count != Full);
  assign push    = finish_valid_i && finish_ready_o;
  assign pop     = b_valid_i && b_ready_o;
  assign aw_fire = aw_valid_o && aw_ready_i;
  assign w_fire  = w_valid_o && w_ready_i;

  assign aw_addr_o = addr_mem[rd_ptr];
  assign w_last_o  = w_valid_o;
  assign busy_o    = (count != '0) || (state != Idle);

  always_comb begin
    w_data_o = '0;
    w_data_o[IdWidth-1:0] = id_mem[rd_ptr];
  end

  // Storage needs no reset: entries are only read once the occupancy covers them.
  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_mem[wr_ptr] <= finish_addr_i;
      id_mem[wr_ptr]   <= finish_dma_id_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PtrW'(1);
      if (pop)  rd_ptr <= rd_ptr + PtrW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PtrW+1)'(1);
        2'b01:   count <= count - (PtrW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Idle also sees a same-cycle push so an empty-FIFO request issues one cycle later.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= Idle;
      aw_valid_o <= 1'b0;
      w_valid_o  <= 1'b0;
      b_ready_o  <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      error_o    <= 1'b0;
      sent_cnt_o <= 32'd0;
    end else begin
      case (state)
        Idle: begin
          if ((count != '0) || push) begin
            state      <= Issue;
            aw_valid_o <= 1'b1;
            w_valid_o  <= 1'b1;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
          end
        end
        Issue: begin
          if (aw_fire) begin
            aw_done    <= 1'b1;
            aw_valid_o <= 1'b0;
          end
          if (w_fire) begin
            w_done    <= 1'b1;
            w_valid_o <= 1'b0;
          end
          if ((aw_done || aw_fire) && (w_done || w_fire)) begin
            state     <= WaitResp;
            b_ready_o <= 1'b1;
          end
        end
        WaitResp: begin
          if (b_valid_i) begin
            state      <= Idle;
            b_ready_o  <= 1'b0;
            sent_cnt_o <= sent_cnt_o + 32'd1;
            if (b_resp_i != 2'b00) error_o <= 1'b1;
          end
        end
        default: begin
          state      <= Idle;
          aw_valid_o <= 1'b0;
          w_valid_o  <= 1'b0;
          b_ready_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xdma_finish_tx.sv
// Randomized bench for xdma_finish_tx against a queue-based transaction model,
// plus directed scenarios for the basic write, backpressure, error and reset.
module tb_xdma_finish_tx;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         finish_valid_i;
  logic         finish_ready_o;
  logic [47:0]  finish_addr_i;
  logic [7:0]   finish_dma_id_i;
  logic         aw_valid_o;
  logic         aw_ready_i;
  logic [47:0]  aw_addr_o;
  logic         w_valid_o;
  logic         w_ready_i;
  logic [511:0] w_data_o;
  logic         w_last_o;
  logic         b_valid_i;
  logic         b_ready_o;
  logic [1:0]   b_resp_i;
  logic         busy_o;
  logic         error_o;
  logic [31:0]  sent_cnt_o;

  always #5 clk = ~clk;

  xdma_finish_tx dut (
    .clk_i(clk), .rst_i(rst_i),
    .finish_valid_i(finish_valid_i), .finish_ready_o(finish_ready_o),
    .finish_addr_i(finish_addr_i), .finish_dma_id_i(finish_dma_id_i),
    .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_addr_o(aw_addr_o),
    .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_data_o(w_data_o), .w_last_o(w_last_o),
    .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_resp_i(b_resp_i),
    .busy_o(busy_o), .error_o(error_o), .sent_cnt_o(sent_cnt_o)
  );

  typedef struct {
    logic [47:0] addr;
    logic [7:0]  id;
  } entry_t;

  // Model: pending requests in order, plus progress of the head's write.
  entry_t      q[$];
  bit          inflight;
  bit          aw_acc;
  bit          w_acc;
  int unsigned m_sent;
  bit          m_err;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_aw  = 0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic fv, input logic [47:0] a, input logic [7:0] id,
                      input logic awr, input logic wr, input logic bv,
                      input logic [1:0] resp, input logic rst);
    bit was;
    bit push;
    logic [511:0] ed;
    rst_i = rst; finish_valid_i = fv; finish_addr_i = a; finish_dma_id_i = id;
    aw_ready_i = awr; w_ready_i = wr; b_valid_i = bv; b_resp_i = resp;
    if (rst) begin
      q.delete(); inflight = 1'b0; aw_acc = 1'b0; w_acc = 1'b0; m_sent = 0; m_err = 1'b0;
    end else begin
      push = fv && (q.size() < 4);
      was  = inflight;
      if (inflight) begin
        if (aw_acc && w_acc) begin
          if (bv) begin
            void'(q.pop_front());
            m_sent++;
            if (resp != 2'b00) m_err = 1'b1;
            inflight = 1'b0;
          end
        end else begin
          if (awr && !aw_acc) n_aw++;
          if (awr) aw_acc = 1'b1;
          if (wr)  w_acc  = 1'b1;
        end
      end
      if (push) q.push_back('{addr: a, id: id});
      if (!was && q.size() != 0) begin
        inflight = 1'b1; aw_acc = 1'b0; w_acc = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check("finish_ready", finish_ready_o, q.size() < 4);
    check("aw_valid", aw_valid_o, inflight && !aw_acc);
    check("w_valid", w_valid_o, inflight && !w_acc);
    check("w_last", w_last_o, inflight && !w_acc);
    check("b_ready", b_ready_o, inflight && aw_acc && w_acc);
    check("busy", busy_o, (q.size() != 0) || inflight);
    check("error", error_o, m_err);
    check("sent_cnt", sent_cnt_o, m_sent);
    if (inflight && !aw_acc) check("aw_addr", aw_addr_o, q[0].addr);
    if (inflight && !w_acc) begin
      ed = '0;
      ed[7:0] = q[0].id;
      check("w_data", w_data_o, ed);
    end
  endtask

  task automatic idle(input logic awr, input logic wr, input logic bv, input logic [1:0] resp);
    step(1'b0, 48'h0, 8'h0, awr, wr, bv, resp, 1'b0);
  endtask

  task automatic push1(input logic [47:0] a, input logic [7:0] id,
                       input logic awr, input logic wr);
    step(1'b1, a, id, awr, wr, 1'b0, 2'b00, 1'b0);
  endtask

  initial begin
    step(1'b0, 48'h0, 8'h0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
    check("reset_ready", finish_ready_o, 1'b1);
    check("reset_busy", busy_o, 1'b0);

    // Basic finish write, ready held high, OKAY response.
    push1(48'h1000, 8'h05, 1'b1, 1'b1);
    check("basic_aw_valid", aw_valid_o, 1'b1);
    check("basic_aw_addr", aw_addr_o, 48'h1000);
    check("basic_w_data", w_data_o, 512'h05);
    idle(1'b1, 1'b1, 1'b0, 2'b00);
    idle(1'b1, 1'b1, 1'b1, 2'b00);
    check("basic_sent", sent_cnt_o, 32'd1);
    check("basic_busy", busy_o, 1'b0);

    // AW accepted 3 cycles late, W immediately.
    push1(48'h2222_0000, 8'h3c, 1'b0, 1'b1);
    idle(1'b0, 1'b1, 1'b0, 2'b00);
    check("late_w_dropped", w_valid_o, 1'b0);
    check("late_aw_held", aw_addr_o, 48'h2222_0000);
    check("late_no_bready", b_ready_o, 1'b0);
    idle(1'b0, 1'b0, 1'b0, 2'b00);
    idle(1'b1, 1'b0, 1'b0, 2'b00);
    check("late_bready", b_ready_o, 1'b1);
    idle(1'b0, 1'b0, 1'b1, 2'b00);

    // Five back-to-back requests into a depth-4 FIFO with B stalled, then error response.
    for (int i = 0; i < 5; i++) push1(48'h3000 + 48'(i), 8'(8'h10 + i), 1'b1, 1'b1);
    check("full_refuses", finish_ready_o, 1'b0);
    push1(48'h3004, 8'h14, 1'b1, 1'b1);
    idle(1'b1, 1'b1, 1'b1, 2'b10);
    check("err_set", error_o, 1'b1);
    push1(48'h3004, 8'h14, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) idle(1'b1, 1'b1, 1'b1, 2'b00);
    check("err_sticky", error_o, 1'b1);
    check("five_sent", sent_cnt_o, 32'd7);

    // Reset while waiting for a response with two entries queued behind it.
    for (int i = 0; i < 3; i++) push1(48'h4000 + 48'(i), 8'(i), 1'b1, 1'b1);
    idle(1'b1, 1'b1, 1'b0, 2'b00);
    check("pre_rst_bready", b_ready_o, 1'b1);
    step(1'b0, 48'h0, 8'h0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
    check("rst_busy", busy_o, 1'b0);
    check("rst_aw_valid", aw_valid_o, 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b0, 1'b0, 1'b1, 2'b11);
    check("stray_b_sent", sent_cnt_o, 32'd0);
    check("stray_b_err", error_o, 1'b0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 1) == 1, {16'($urandom), 32'($urandom)}, 8'($urandom),
           $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 4,
           ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00,
           $urandom_range(0, 299) == 0);
    end
    for (int i = 0; i < 40; i++) idle(1'b1, 1'b1, 1'b1, 2'b00);
    check("drain_busy", busy_o, 1'b0);
    check("aw_handshakes_seen", n_aw > 100, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
